// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg -- shared definitions for the two-requester ALU arbiter:
// FSM state encoding, MIPS funct code constants and the funct legality helper.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_NOOP = 6'h2C;

   // True for the funct codes the shared ALU implements.
   function automatic logic funct_is_valid(input logic [5:0] f);
      case (f)
         FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR,
         FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_NOOP: funct_is_valid = 1'b1;
         default:                                     funct_is_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundles the two request channels, the shared-ALU port and
// the response channel. The slave modport is the arbiter's view; master is
// the surrounding system (requesters, ALU and response consumer).
interface alu_arbiter_if #(
   parameter int DATA_W = 32
);

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [5:0]        req0_funct;
   logic              req0_cin;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [5:0]        req1_funct;
   logic              req1_cin;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [5:0]        alu_funct;
   logic              alu_cin;
   logic [DATA_W-1:0] alu_res;
   logic              alu_zero;
   logic              alu_ovf;
   logic              alu_cout;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_res;
   logic              rsp_zero;
   logic              rsp_ovf;
   logic              rsp_cout;
   logic              rsp_err;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_funct, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_funct, req1_cin,
      output req1_ready,
      output alu_a, alu_b, alu_funct, alu_cin,
      input  alu_res, alu_zero, alu_ovf, alu_cout,
      output rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_ovf, rsp_cout, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_funct, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_funct, req1_cin,
      input  req1_ready,
      input  alu_a, alu_b, alu_funct, alu_cin,
      output alu_res, alu_zero, alu_ovf, alu_cout,
      input  rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_ovf, rsp_cout, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2 -- two-way round-robin grant. last_grant=1 means requester 1 won
// the previous arbitration, so requester 0 is preferred on a tie.
module rr_arb2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant: a lone requester always wins, a tie goes to the one not served last.
   always_comb begin
      grant    = 2'b00;
      grant[0] = valid0 & (~valid1 | last_grant);
      grant[1] = valid1 & (~valid0 | ~last_grant);
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one external ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP: operands are captured on accept,
// presented to the ALU for one cycle, and the result is held until the
// response handshake completes.
// Optional feature: define ALU_ARB_FUNCT_CHECK_EN to reject unknown funct
// codes (they bypass the ALU and answer with rsp_err=1).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   state_t            state;
   logic              last_grant;
   logic [1:0]        grant;
   logic              take;
   logic              accept;
   logic              sel;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [5:0]        sel_funct;
   logic              sel_cin;

   logic [DATA_W-1:0] alu_a_p0;
   logic [DATA_W-1:0] alu_b_p0;
   logic [5:0]        alu_funct_p0;
   logic              alu_cin_p0;
   logic              id_p0;
   logic              noop_p0;
   logic              bypass_p0;

   logic              vld_p1;
   logic              rsp_id_p1;
   logic [DATA_W-1:0] rsp_res_p1;
   logic              rsp_zero_p1;
   logic              rsp_ovf_p1;
   logic              rsp_cout_p1;

`ifdef ALU_ARB_FUNCT_CHECK_EN
   logic              err_p0;
   logic              rsp_err_p1;
   assign bypass_p0   = noop_p0 | err_p0;
   assign bus.rsp_err = rsp_err_p1;
`else
   assign bypass_p0   = noop_p0;
   assign bus.rsp_err = 1'b0;
`endif

   // An unresolved ALU bit (X or Z) is never passed on; it reads as 0.
   function automatic logic [DATA_W-1:0] clean_word(input logic [DATA_W-1:0] v);
      for (int i = 0; i < DATA_W; i++) begin
         clean_word[i] = (v[i] === 1'b1);
      end
   endfunction

   function automatic logic clean_bit(input logic v);
      clean_bit = (v === 1'b1);
   endfunction

   rr_arb2 u_rr_arb2 (
      .valid0     (bus.req0_valid),
      .valid1     (bus.req1_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Ready is offered only in IDLE, outside reset, to the single granted requester.
   always_comb begin
      take           = (state == IDLE) && !reset;
      bus.req0_ready = take & grant[0];
      bus.req1_ready = take & grant[1];
      accept         = bus.req0_ready | bus.req1_ready;
      sel            = grant[1];
      sel_a          = sel ? bus.req1_a     : bus.req0_a;
      sel_b          = sel ? bus.req1_b     : bus.req0_b;
      sel_funct      = sel ? bus.req1_funct : bus.req0_funct;
      sel_cin        = sel ? bus.req1_cin   : bus.req0_cin;
   end

   assign bus.alu_a     = alu_a_p0;
   assign bus.alu_b     = alu_b_p0;
   assign bus.alu_funct = alu_funct_p0;
   assign bus.alu_cin   = alu_cin_p0;

   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_id    = rsp_id_p1;
   assign bus.rsp_res   = rsp_res_p1;
   assign bus.rsp_zero  = rsp_zero_p1;
   assign bus.rsp_ovf   = rsp_ovf_p1;
   assign bus.rsp_cout  = rsp_cout_p1;

   // Operation FSM with registered ALU drive and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         alu_a_p0     <= '0;
         alu_b_p0     <= '0;
         alu_funct_p0 <= FUNCT_NOOP;
         alu_cin_p0   <= 1'b0;
         vld_p1       <= 1'b0;
         rsp_id_p1    <= 1'b0;
         rsp_res_p1   <= '0;
         rsp_zero_p1  <= 1'b0;
         rsp_ovf_p1   <= 1'b0;
         rsp_cout_p1  <= 1'b0;
`ifdef ALU_ARB_FUNCT_CHECK_EN
         rsp_err_p1   <= 1'b0;
`endif
      end else begin
         case (state)
            // p0: capture the granted request; the requester is free afterwards.
            IDLE: begin
               if (accept) begin
                  state      <= EXEC;
                  last_grant <= sel;
                  id_p0      <= sel;
                  noop_p0    <= (sel_funct == FUNCT_NOOP);
`ifdef ALU_ARB_FUNCT_CHECK_EN
                  err_p0     <= !funct_is_valid(sel_funct);
                  if (funct_is_valid(sel_funct)) begin
                     alu_a_p0     <= sel_a;
                     alu_b_p0     <= sel_b;
                     alu_funct_p0 <= sel_funct;
                     alu_cin_p0   <= sel_cin;
                  end
`else
                  alu_a_p0     <= sel_a;
                  alu_b_p0     <= sel_b;
                  alu_funct_p0 <= sel_funct;
                  alu_cin_p0   <= sel_cin;
`endif
               end
            end
            // p1: sample the ALU at the end of EXEC and return it to idle values.
            EXEC: begin
               state        <= RESP;
               vld_p1       <= 1'b1;
               rsp_id_p1    <= id_p0;
               alu_a_p0     <= '0;
               alu_b_p0     <= '0;
               alu_funct_p0 <= FUNCT_NOOP;
               alu_cin_p0   <= 1'b0;
               if (bypass_p0) begin
                  rsp_res_p1  <= '0;
                  rsp_zero_p1 <= 1'b0;
                  rsp_ovf_p1  <= 1'b0;
                  rsp_cout_p1 <= 1'b0;
               end else begin
                  rsp_res_p1  <= clean_word(bus.alu_res);
                  rsp_zero_p1 <= clean_bit(bus.alu_zero);
                  rsp_ovf_p1  <= clean_bit(bus.alu_ovf);
                  rsp_cout_p1 <= clean_bit(bus.alu_cout);
               end
`ifdef ALU_ARB_FUNCT_CHECK_EN
               rsp_err_p1   <= err_p0;
`endif
            end
            // Hold the response until the consumer takes it.
            RESP: begin
               if (bus.rsp_ready) begin
                  vld_p1 <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed bench for alu_arbiter with a behavioural ALU.
// Honours ALU_ARB_FUNCT_CHECK_EN for the illegal-funct vector.
module tb_alu_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(32)) bus ();

   alu_arbiter #(.DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural ALU; NOOP returns garbage so a forwarded value would be visible.
   logic [32:0] sum;
   always_comb begin
      sum          = '0;
      bus.alu_res  = 32'hDEADBEEF;
      bus.alu_ovf  = 1'b0;
      bus.alu_cout = 1'b0;
      case (bus.alu_funct)
         6'h20: begin
            sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'b0, bus.alu_cin};
            bus.alu_res  = sum[31:0];
            bus.alu_cout = sum[32];
            bus.alu_ovf  = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
         end
         6'h22: begin
            sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
            bus.alu_res  = sum[31:0];
            bus.alu_cout = sum[32];
            bus.alu_ovf  = (bus.alu_a[31] != bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
         end
         6'h24: bus.alu_res = bus.alu_a & bus.alu_b;
         6'h25: bus.alu_res = bus.alu_a | bus.alu_b;
         6'h26: bus.alu_res = bus.alu_a ^ bus.alu_b;
         6'h27: bus.alu_res = ~(bus.alu_a | bus.alu_b);
         6'h2A: bus.alu_res = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
         6'h2C: begin
            bus.alu_res  = 32'hFFFFFFFF;
            bus.alu_ovf  = 1'b1;
            bus.alu_cout = 1'b1;
         end
         default: ;
      endcase
      bus.alu_zero = (bus.alu_res == 32'd0);
   end

   typedef struct {
      logic        id;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        cout;
      logic        err;
      logic [31:0] ex_a;
      logic [5:0]  ex_f;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic id, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input logic [31:0] res,
                               input logic z, input logic o, input logic c);
      vec_t v;
      v.id = id;  v.funct = f;  v.a = a;  v.b = b;  v.cin = cin;
      v.res = res;  v.zero = z;  v.ovf = o;  v.cout = c;  v.err = 1'b0;
      v.ex_a = a;  v.ex_f = f;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input logic id);
      return id ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic set_req(input logic id, input logic v, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic cin);
      if (id == 1'b0) begin
         bus.req0_valid = v;  bus.req0_funct = f;  bus.req0_a = a;  bus.req0_b = b;  bus.req0_cin = cin;
      end else begin
         bus.req1_valid = v;  bus.req1_funct = f;  bus.req1_a = a;  bus.req1_b = b;  bus.req1_cin = cin;
      end
   endtask

   // One complete operation with the consumer always ready.
   task automatic do_op(input vec_t v);
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      set_req(v.id, 1'b1, v.funct, v.a, v.b, v.cin);
      #1;
      chk1("op_ready_own", rdy(v.id), 1'b1);
      chk1("op_ready_other", rdy(!v.id), 1'b0);
      @(negedge clk);
      set_req(v.id, 1'b0, 6'h00, ~v.a, ~v.b, ~v.cin);
      #1;
      chk1("op_exec_rsp_valid", bus.rsp_valid, 1'b0);
      chk32("op_exec_alu_a", bus.alu_a, v.ex_a);
      chk32("op_exec_alu_funct", {26'b0, bus.alu_funct}, {26'b0, v.ex_f});
      @(negedge clk);
      #1;
      chk1("op_rsp_valid", bus.rsp_valid, 1'b1);
      chk1("op_rsp_id", bus.rsp_id, v.id);
      chk32("op_rsp_res", bus.rsp_res, v.res);
      chk1("op_rsp_zero", bus.rsp_zero, v.zero);
      chk1("op_rsp_ovf", bus.rsp_ovf, v.ovf);
      chk1("op_rsp_cout", bus.rsp_cout, v.cout);
      chk1("op_rsp_err", bus.rsp_err, v.err);
      chk32("op_resp_alu_funct", {26'b0, bus.alu_funct}, 32'h2C);
      chk32("op_resp_alu_a", bus.alu_a, 32'h0);
      @(negedge clk);
      #1;
      chk1("op_done_rsp_valid", bus.rsp_valid, 1'b0);
   endtask

   initial begin
      vecs[0]  = mk(1'b0, 6'h20, 32'd5,        32'd3,        1'b0, 32'd8,        1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 6'h20, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mk(1'b0, 6'h20, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 1'b0, 1'b1);
      vecs[3]  = mk(1'b1, 6'h20, 32'd1,        32'd1,        1'b1, 32'd3,        1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 6'h22, 32'd7,        32'd7,        1'b0, 32'd0,        1'b1, 1'b0, 1'b1);
      vecs[5]  = mk(1'b1, 6'h22, 32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 6'h22, 32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
      vecs[7]  = mk(1'b1, 6'h2A, 32'd2,        32'd9,        1'b0, 32'd1,        1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 6'h2A, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 6'h24, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 6'h25, 32'h0000F0F0, 32'h00000F0F, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(1'b1, 6'h26, 32'h000000FF, 32'h0000000F, 1'b0, 32'h000000F0, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 6'h27, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      vecs[13] = mk(1'b1, 6'h2C, 32'd5,        32'd6,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0);
`ifdef ALU_ARB_FUNCT_CHECK_EN
      vecs[14] = mk(1'b0, 6'h3F, 32'd9,        32'd4,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0);
      vecs[14].err  = 1'b1;
      vecs[14].ex_a = 32'd0;
      vecs[14].ex_f = 6'h2C;
`else
      vecs[14] = mk(1'b0, 6'h3F, 32'd9,        32'd4,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
`endif

      set_req(1'b0, 1'b1, 6'h20, 32'd0, 32'd0, 1'b0);
      set_req(1'b1, 1'b0, 6'h20, 32'd0, 32'd0, 1'b0);
      bus.rsp_ready = 1'b1;

      // Reset state, with req0 valid to show ready stays low during reset.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk1("rst_ready0", bus.req0_ready, 1'b0);
      chk1("rst_ready1", bus.req1_ready, 1'b0);
      chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("rst_rsp_id", bus.rsp_id, 1'b0);
      chk32("rst_rsp_res", bus.rsp_res, 32'h0);
      chk1("rst_rsp_err", bus.rsp_err, 1'b0);
      chk32("rst_alu_funct", {26'b0, bus.alu_funct}, 32'h2C);
      chk32("rst_alu_a", bus.alu_a, 32'h0);
      set_req(1'b0, 1'b0, 6'h20, 32'd0, 32'd0, 1'b0);
      reset = 1'b0;

      // Contention from reset: req0 first, then round-robin alternates.
      @(negedge clk);
      set_req(1'b0, 1'b1, 6'h22, 32'd7, 32'd7, 1'b0);
      set_req(1'b1, 1'b1, 6'h2A, 32'd2, 32'd9, 1'b0);
      #1;
      chk1("cont_c0_ready0", bus.req0_ready, 1'b1);
      chk1("cont_c0_ready1", bus.req1_ready, 1'b0);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      chk1("cont_c1_ready1", bus.req1_ready, 1'b0);
      chk1("cont_c1_rsp_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      set_req(1'b0, 1'b1, 6'h24, 32'h0000F0F0, 32'h0000FF00, 1'b0);
      #1;
      chk1("cont_c2_rsp_valid", bus.rsp_valid, 1'b1);
      chk1("cont_c2_rsp_id", bus.rsp_id, 1'b0);
      chk32("cont_c2_rsp_res", bus.rsp_res, 32'h0);
      chk1("cont_c2_rsp_zero", bus.rsp_zero, 1'b1);
      chk1("cont_c2_ready0", bus.req0_ready, 1'b0);
      chk1("cont_c2_ready1", bus.req1_ready, 1'b0);
      @(negedge clk);
      #1;
      chk1("cont_c3_ready1", bus.req1_ready, 1'b1);
      chk1("cont_c3_ready0", bus.req0_ready, 1'b0);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #1;
      chk1("cont_c4_ready0", bus.req0_ready, 1'b0);
      @(negedge clk);
      #1;
      chk1("cont_c5_rsp_valid", bus.rsp_valid, 1'b1);
      chk1("cont_c5_rsp_id", bus.rsp_id, 1'b1);
      chk32("cont_c5_rsp_res", bus.rsp_res, 32'd1);
      chk1("cont_c5_rsp_zero", bus.rsp_zero, 1'b0);
      @(negedge clk);
      #1;
      chk1("cont_c6_ready0", bus.req0_ready, 1'b1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      #1;
      chk1("cont_c8_rsp_id", bus.rsp_id, 1'b0);
      chk32("cont_c8_rsp_res", bus.rsp_res, 32'h0000F000);
      @(negedge clk);
      #1;
      chk1("cont_c9_rsp_valid", bus.rsp_valid, 1'b0);

      // Table of single operations.
      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i]);
      end

      // Backpressure: rsp_ready low for four RESP cycles while req1 waits.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 6'h20, 32'd5, 32'd3, 1'b0);
      #1;
      chk1("bp_c0_ready0", bus.req0_ready, 1'b1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      set_req(1'b1, 1'b1, 6'h25, 32'h0F, 32'hF0, 1'b0);
      #1;
      chk1("bp_c1_ready1", bus.req1_ready, 1'b0);
      for (int c = 2; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk1("bp_hold_rsp_valid", bus.rsp_valid, 1'b1);
         chk32("bp_hold_rsp_res", bus.rsp_res, 32'd8);
         chk1("bp_hold_rsp_id", bus.rsp_id, 1'b0);
         chk1("bp_hold_ready0", bus.req0_ready, 1'b0);
         chk1("bp_hold_ready1", bus.req1_ready, 1'b0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #1;
      chk1("bp_c6_rsp_valid", bus.rsp_valid, 1'b1);
      chk32("bp_c6_rsp_res", bus.rsp_res, 32'd8);
      @(negedge clk);
      #1;
      chk1("bp_c7_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("bp_c7_ready1", bus.req1_ready, 1'b1);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      @(negedge clk);
      #1;
      chk1("bp_c9_rsp_id", bus.rsp_id, 1'b1);
      chk32("bp_c9_rsp_res", bus.rsp_res, 32'hFF);

      // Reset during EXEC drops the operation and restores req0 priority.
      @(negedge clk);
      set_req(1'b0, 1'b1, 6'h20, 32'd1, 32'd2, 1'b0);
      #1;
      chk1("rx_c0_ready0", bus.req0_ready, 1'b1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk32("rx_c1_alu_a", bus.alu_a, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("rx_c2_rsp_valid", bus.rsp_valid, 1'b0);
      chk32("rx_c2_alu_funct", {26'b0, bus.alu_funct}, 32'h2C);
      @(negedge clk);
      #1;
      chk1("rx_c3_rsp_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      set_req(1'b0, 1'b1, 6'h26, 32'h3, 32'h5, 1'b0);
      set_req(1'b1, 1'b1, 6'h26, 32'h1, 32'h1, 1'b0);
      #1;
      chk1("rx_c4_ready0", bus.req0_ready, 1'b1);
      chk1("rx_c4_ready1", bus.req1_ready, 1'b0);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      chk1("rx_c5_rsp_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      #1;
      chk1("rx_c6_rsp_valid", bus.rsp_valid, 1'b1);
      chk1("rx_c6_rsp_id", bus.rsp_id, 1'b0);
      chk32("rx_c6_rsp_res", bus.rsp_res, 32'h6);
      @(negedge clk);
      #1;
      chk1("rx_c7_rsp_valid", bus.rsp_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
